data_memory_responder: RTL and testbench

Multicycle responder side of the MEM-stage data-memory interface. It accepts one read or write request at a time from the MEM stage and services it after a programmable number of wait states. It signals completion with a one-cycle ready pulse so the controller can stall until the access finishes. It owns the word storage and the byte-address-to-word-index mapping (base offset, alignment and range checks).

---
 rtl/data_memory_responder_pkg.sv | 19 +
 rtl/data_memory_responder_mem_addr_decode.sv | 26 ++
 rtl/data_memory_responder.sv | 127 ++++++++++++
 tb/tb_data_memory_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the FSM state encoding, the operation encoding and the address-map defaults.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEFAULT_BASE_ADDR = 1024;
  localparam int WORD_BYTES        = 4;

endpackage

// File: rtl/data_memory_responder_mem_addr_decode.sv
// Maps a byte address onto a word index relative to BASE_ADDR.
// It also flags misaligned addresses and addresses outside the DEPTH-word window.
module mem_addr_decode
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'(DEFAULT_BASE_ADDR),
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] index,
  output logic             misaligned,
  output logic             out_of_range
);

  logic [31:0] offset;

  // Unsigned wrap makes anything below BASE_ADDR land far outside the window.
  always_comb begin
    offset       = addr - BASE_ADDR;
    index        = offset[IDX_W+1:2];
    misaligned   = (offset[1:0] != 2'b00);
    out_of_range = ({2'b00, offset[31:2]} >= 32'(DEPTH));
  end

endmodule

// File: rtl/data_memory_responder.sv
// Multicycle data-memory responder for the MEM stage.
// It accepts one request, waits WAIT_CYCLES cycles, and then pulses ready with the result.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR),
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] write_val,
  output logic [31:0] read_val,
  output logic        ready,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  op_t               lat_op;
  logic              lat_conflict;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       read_q;
  logic              err_q;

  logic              req;
  op_t               cur_op;
  logic              cur_conflict;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic              enter_resp;

  // With zero wait states RESP is entered straight from IDLE, so the access uses the live inputs.
  always_comb begin
    req          = MEM_R_EN | MEM_W_EN;
    cur_op       = lat_op;
    cur_conflict = lat_conflict;
    cur_addr     = lat_addr;
    cur_wdata    = lat_wdata;
    if (state == IDLE) begin
      cur_op       = MEM_W_EN ? OP_WR : OP_RD;
      cur_conflict = MEM_R_EN & MEM_W_EN;
      cur_addr     = addr;
      cur_wdata    = write_val;
    end
  end

  mem_addr_decode #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr         (cur_addr),
    .index        (idx),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  assign access_err = misaligned | out_of_range | cur_conflict;

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == CNT_W'(1)) next_state = RESP;
      RESP: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign enter_resp = (next_state == RESP) && (state != RESP);

  // The write commit and the registered response share the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_op       <= OP_RD;
      lat_conflict <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      read_q       <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        lat_op       <= cur_op;
        lat_conflict <= cur_conflict;
        lat_addr     <= addr;
        lat_wdata    <= write_val;
        cnt          <= CNT_W'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        err_q <= access_err;
        if (access_err) begin
          read_q <= '0;
        end else if (cur_op == OP_RD) begin
          read_q <= mem[idx];
        end else begin
          mem[idx] <= cur_wdata;
        end
      end
    end
  end

  assign read_val = read_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a table of vectors with a scoreboard,
// plus hand-written sequences for reset abort, back-to-back requests and a zero-wait build.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] addr, wval;
  logic [31:0] rval;
  logic        rdy, err;

  logic        r_en0, w_en0;
  logic [31:0] addr0, wval0;
  logic [31:0] rval0;
  logic        rdy0, err0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .addr(addr),
    .write_val(wval), .read_val(rval), .ready(rdy), .err(err)
  );

  data_memory_responder #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0), .addr(addr0),
    .write_val(wval0), .read_val(rval0), .ready(rdy0), .err(err0)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("ready_cycle", 32'(cyc), 32'(e.due));
        check_output("read_val", rval, e.rd);
        check_output("err", {31'd0, err}, {31'd0, e.er});
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic er, input int start);
    exp_t e;
    e.rd  = rd;
    e.er  = er;
    e.due = start + W + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check_output("response_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] exp_rd,
                                input logic exp_err, input bit hold);
    @(negedge clk);
    r_en = r;
    w_en = w;
    addr = a;
    wval = d;
    push_exp(exp_rd, exp_err, cyc);
    wait_done();
    if (!hold) begin
      r_en = 1'b0;
      w_en = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic saw_ready;

    vecs[0]  = '{"wr_1024",       1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{"rd_1024",       1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"rd_1028",       1'b1, 1'b0, 32'd1028, 32'h0,        32'h00000000, 1'b0};
    vecs[3]  = '{"wr_1276",       1'b0, 1'b1, 32'd1276, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{"rd_1276",       1'b1, 1'b0, 32'd1276, 32'h0,        32'h00000001, 1'b0};
    vecs[5]  = '{"wr_1280_oor",   1'b0, 1'b1, 32'd1280, 32'hAAAA5555, 32'h00000000, 1'b1};
    vecs[6]  = '{"wr_1020_below", 1'b0, 1'b1, 32'd1020, 32'hAAAA5555, 32'h00000000, 1'b1};
    vecs[7]  = '{"rd_1024_kept",  1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[8]  = '{"rd_1026_mis",   1'b1, 1'b0, 32'd1026, 32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{"both_1024",     1'b1, 1'b1, 32'd1024, 32'h55555555, 32'h00000000, 1'b1};
    vecs[10] = '{"rd_1024_again", 1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[11] = '{"wr_1024_new",   1'b0, 1'b1, 32'd1024, 32'h11111111, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{"rd_1024_new",   1'b1, 1'b0, 32'd1024, 32'h0,        32'h11111111, 1'b0};
    vecs[13] = '{"rd_0_wrap",     1'b1, 1'b0, 32'd0,    32'h0,        32'h00000000, 1'b1};

    rst = 1'b1;
    r_en = 1'b0; w_en = 1'b0; addr = '0; wval = '0;
    r_en0 = 1'b0; w_en0 = 1'b0; addr0 = '0; wval0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_output("reset_ready", {31'd0, rdy}, 32'd0);
    check_output("reset_read_val", rval, 32'd0);
    check_output("reset_err", {31'd0, err}, 32'd0);

    foreach (vecs[i]) begin
      $display("[TB] vector %0d %s", i, vecs[i].name);
      apply_stimulus(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
                     vecs[i].exp_rd, vecs[i].exp_err, 1'b0);
    end

    // Make read_val non-zero so the abort visibly returns it to its reset value.
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    r_en = 1'b0; w_en = 1'b1; addr = 32'd1032; wval = 32'h12345678;
    @(negedge clk);
    rst  = 1'b1;
    w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rdy === 1'b1) saw_ready = 1'b1;
      @(negedge clk);
    end
    check_output("abort_no_ready", {31'd0, saw_ready}, 32'd0);
    check_output("abort_read_val", rval, 32'd0);
    check_output("abort_err", {31'd0, err}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd1032, 32'h0, 32'h00000000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'h00000000, 1'b0, 1'b0);

    // Back-to-back: enables stay high through ready, and the address moves to the next word.
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0BADC0DE, 32'h00000000, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'h0BADC0DE, 1'b0, 1'b1);
    addr = 32'd1028;
    push_exp(32'hCAFEF00D, 1'b0, cyc + 1);
    wait_done();
    r_en = 1'b0;
    @(negedge clk);
    check_output("b2b_ready_low", {31'd0, rdy}, 32'd0);

    // Zero-wait build: ready must appear in the cycle right after the request.
    @(negedge clk);
    w_en0 = 1'b1; addr0 = 32'd1024; wval0 = 32'h5A5A5A5A;
    @(negedge clk);
    check_output("w0_wr_ready", {31'd0, rdy0}, 32'd1);
    check_output("w0_wr_err", {31'd0, err0}, 32'd0);
    w_en0 = 1'b0;
    @(negedge clk);
    check_output("w0_ready_low", {31'd0, rdy0}, 32'd0);
    r_en0 = 1'b1;
    @(negedge clk);
    check_output("w0_rd_ready", {31'd0, rdy0}, 32'd1);
    check_output("w0_rd_val", rval0, 32'h5A5A5A5A);
    r_en0 = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
